// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types, constants and helpers for the hazard controller
// Contents:
//   hz_state_t   MDU sequencing state (RUN / MDU_WAIT)
//   hz_ctrl_t    the six stall/flush control bits driven into the pipeline
//   CTRL_*       canned control vectors for each arbitration outcome
//   reg_match    true when a nonzero register is read by the instruction in ID
package pipeline_hazard_ctrl_pkg;

    localparam int MDU_LAT_DEF = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_stall;
        logic if_flush;
        logic id_flush;
        logic ex_flush;
        logic mem_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE  = '0;
    localparam hz_ctrl_t CTRL_EXC   = '{pc_stall: 1'b0, if_stall: 1'b0, if_flush: 1'b1,
                                        id_flush: 1'b1, ex_flush: 1'b1, mem_flush: 1'b1};
    localparam hz_ctrl_t CTRL_MISP  = '{pc_stall: 1'b0, if_stall: 1'b0, if_flush: 1'b1,
                                        id_flush: 1'b1, ex_flush: 1'b1, mem_flush: 1'b0};
    localparam hz_ctrl_t CTRL_STALL = '{pc_stall: 1'b1, if_stall: 1'b1, if_flush: 1'b0,
                                        id_flush: 1'b1, ex_flush: 1'b0, mem_flush: 1'b0};

    // $0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic use_rs,
                                       input logic use_rt);
        return (r != 5'd0) && ((use_rs && rs == r) || (use_rt && rt == r));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_busy_counter.sv
// pipeline_hazard_ctrl_mdu_busy_counter: tracks multi-cycle MDU occupancy after an issue
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset (state RUN, count 0)
//   i_start   mult/div issuing in EX this cycle; (re)loads the countdown
//   o_busy    high while in MDU_WAIT
module pipeline_hazard_ctrl_mdu_busy_counter
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_busy
);

    localparam int CW = $clog2(MDU_LAT);

    hz_state_t     r_state;
    logic [CW-1:0] r_cnt;

    // A start seen while already waiting simply reloads; flushes never abort
    // the countdown because HI/LO are still written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_state <= MDU_WAIT;
            r_cnt   <= CW'(MDU_LAT - 1);
        end else if (r_state == MDU_WAIT) begin
            r_cnt   <= r_cnt - 1'b1;
            r_state <= (r_cnt == CW'(1)) ? RUN : MDU_WAIT;
        end
    end

    assign o_busy = (r_state == MDU_WAIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline with perf counters
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_id_rs/rt, i_id_use_rs/rt    ID source registers and their usage
//   i_id_branch_use               ID instruction resolves on a GPR in ID
//   i_id_mdu_use                  ID instruction touches the MDU / HI / LO
//   i_ex_rw, i_ex_reg_write       EX destination and write enable
//   i_ex_mem_read, i_ex_mdu_start EX load flag, MDU issue
//   i_mem_rw, i_mem_reg_write     MEM destination and write enable
//   i_mem_mem_read                MEM load flag
//   i_mem_mispredict, i_mem_exc_req  recovery requests from MEM
//   o_pc_stall .. o_mem_flush     stall/flush vector
//   o_mdu_busy                    MDU countdown active
//   o_stall_cnt, o_mispred_cnt    saturating performance counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_id_branch_use,
    input  logic             i_id_mdu_use,
    input  logic [4:0]       i_ex_rw,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_mdu_start,
    input  logic [4:0]       i_mem_rw,
    input  logic             i_mem_reg_write,
    input  logic             i_mem_mem_read,
    input  logic             i_mem_mispredict,
    input  logic             i_mem_exc_req,
    output logic             o_pc_stall,
    output logic             o_if_stall,
    output logic             o_if_flush,
    output logic             o_id_flush,
    output logic             o_ex_flush,
    output logic             o_mem_flush,
    output logic             o_mdu_busy,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    logic             w_mdu_busy;
    logic             w_match_ex;
    logic             w_match_mem;
    logic             w_lu;
    logic             w_br;
    logic             w_mdu;
    logic             w_misp_evt;
    hz_ctrl_t         w_ctrl;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    pipeline_hazard_ctrl_mdu_busy_counter #(.MDU_LAT(MDU_LAT)) u_mdu (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_ex_mdu_start),
        .o_busy  (w_mdu_busy)
    );

    assign w_match_ex  = reg_match(i_ex_rw, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt);
    assign w_match_mem = reg_match(i_mem_rw, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt);

    assign w_lu  = i_ex_mem_read && i_ex_reg_write && w_match_ex;
    // Branches resolve in ID, so any EX result and a load still in MEM are both too late.
    assign w_br  = i_id_branch_use && ((i_ex_reg_write && w_match_ex) ||
                   (i_mem_mem_read && i_mem_reg_write && w_match_mem));
    assign w_mdu = i_id_mdu_use && (w_mdu_busy || i_ex_mdu_start);

    // Flushes outrank stalls; a dropped hazard re-evaluates on the refetched instruction.
    always_comb begin
        w_ctrl = !rst_n                 ? CTRL_NONE  :
                 i_mem_exc_req          ? CTRL_EXC   :
                 i_mem_mispredict       ? CTRL_MISP  :
                 (w_mdu || w_br || w_lu) ? CTRL_STALL : CTRL_NONE;
    end

    assign w_misp_evt = i_mem_mispredict && !i_mem_exc_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt   <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_ctrl.pc_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_misp_evt && !(&r_mispred_cnt))
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    assign o_pc_stall    = w_ctrl.pc_stall;
    assign o_if_stall    = w_ctrl.if_stall;
    assign o_if_flush    = w_ctrl.if_flush;
    assign o_id_flush    = w_ctrl.id_flush;
    assign o_ex_flush    = w_ctrl.ex_flush;
    assign o_mem_flush   = w_ctrl.mem_flush;
    assign o_mdu_busy    = w_mdu_busy;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule
